// File: rtl/cache_refill_ctrl_pkg.sv
// CACHEStruct: shared types for the cache miss/refill path.
package CACHEStruct;

    localparam int unsigned CACHE_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        RD_REQ,
        RD_WAIT,
        FINISH
    } refill_state_t;

    typedef logic [2*CACHE_DATA_WIDTH-1:0] mem_beat_t;

endpackage

// File: rtl/cache_refill_ctrl_wb_buffer.sv
// cache_wb_buffer: holds the dirty victim line and its address, and selects
// one 2*DATA_WIDTH memory beat of it for the writeback.
module cache_wb_buffer #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BANK_NUM   = 4,
    parameter int unsigned CW         = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           load_i,
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    input  logic [BANK_NUM*DATA_WIDTH-1:0] line_i,
    input  logic [CW-1:0]                  beat_i,
    output logic [ADDR_WIDTH-1:0]          addr_o,
    output logic [2*DATA_WIDTH-1:0]        beat_o
);

    localparam int unsigned BW = 2 * DATA_WIDTH;

    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [BANK_NUM*DATA_WIDTH-1:0] line_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q <= '0;
            line_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            line_q <= line_i;
        end
    end

    assign addr_o = addr_q;
    assign beat_o = line_q[beat_i*BW +: BW];

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: captures a bank miss, writes back a dirty victim and
// refills the line beat by beat. `CACHE_WB_READ_FIRST_EN runs the refill first.
module cache_refill_ctrl
    import CACHEStruct::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BANK_NUM   = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           miss_cache,
    input  logic [ADDR_WIDTH-1:0]          addr_cache,
    input  logic                           set_cache,
    input  logic                           need_wb,
    input  logic [ADDR_WIDTH-1:0]          addr_wb,
    input  logic [BANK_NUM*DATA_WIDTH-1:0] data_wb,
    output logic                           busy_wb,
    output logic                           busy_rd,
    output logic [ADDR_WIDTH-1:0]          addr_rd,
    output logic [2*DATA_WIDTH-1:0]        data_rd,
    output logic                           wen_rd,
    output logic                           set_rd,
    output logic                           finish_rd,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [2*DATA_WIDTH-1:0]        mem_wdata,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [2*DATA_WIDTH-1:0]        mem_rdata
);

    localparam int unsigned BEATS = BANK_NUM / 2;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BW    = 2 * DATA_WIDTH;
    localparam logic [CW-1:0]         LAST_BEAT  = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BW / 8);
`ifdef CACHE_WB_READ_FIRST_EN
    localparam bit READ_FIRST = 1'b1;
`else
    localparam bit READ_FIRST = 1'b0;
`endif

    refill_state_t          state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_rd_q, wb_addr, beat_off;
    logic [BW-1:0]          data_rd_q, wb_beat;
    logic                   set_q, busy_rd_q, busy_wb_q, wen_q, finish_q;
    logic                   accept, last_beat, wr_done;

    // busy_rd stays high through the finish_rd cycle, so it also gates capture.
    assign accept    = miss_cache && (state_q == IDLE) && !busy_rd_q && !busy_wb_q;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign wr_done   = (state_q == WB_REQ) && mem_gnt && last_beat;
    assign beat_off  = ADDR_WIDTH'(cnt_q) * BEAT_BYTES;

    cache_wb_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BANK_NUM  (BANK_NUM),
        .CW        (CW)
    ) u_wb_buffer (
        .clk   (clk),
        .rstn  (rstn),
        .load_i(accept && need_wb),
        .addr_i(addr_wb),
        .line_i(data_wb),
        .beat_i(cnt_q),
        .addr_o(wb_addr),
        .beat_o(wb_beat)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = (need_wb && !READ_FIRST) ? WB_REQ : RD_REQ;
            end
            WB_REQ: begin
                if (mem_gnt) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = READ_FIRST ? IDLE : RD_REQ;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = FINISH;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            FINISH: begin
                state_d = (READ_FIRST && busy_wb_q) ? WB_REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_addr + beat_off;
                mem_wdata = wb_beat;
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr_q + beat_off;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q    <= '0;
            set_q     <= 1'b0;
            busy_rd_q <= 1'b0;
            busy_wb_q <= 1'b0;
            wen_q     <= 1'b0;
            finish_q  <= 1'b0;
            addr_rd_q <= '0;
            data_rd_q <= '0;
        end else begin
            wen_q    <= 1'b0;
            finish_q <= (state_q == FINISH);
            if (accept) begin
                addr_q    <= addr_cache;
                set_q     <= set_cache;
                busy_rd_q <= 1'b1;
                busy_wb_q <= need_wb;
            end
            if (finish_q) busy_rd_q <= 1'b0;
            if (wr_done)  busy_wb_q <= 1'b0;
            if ((state_q == RD_WAIT) && mem_rvalid) begin
                wen_q     <= 1'b1;
                data_rd_q <= mem_rdata;
                addr_rd_q <= addr_q + beat_off;
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (!(rstn && miss_cache && !accept))
            else $warning("cache_refill_ctrl: miss_cache ignored while busy");
    end

    assign busy_wb   = busy_wb_q;
    assign busy_rd   = busy_rd_q;
    assign addr_rd   = addr_rd_q;
    assign data_rd   = data_rd_q;
    assign wen_rd    = wen_q;
    assign set_rd    = set_q;
    assign finish_rd = finish_q;

endmodule
